// File: rtl/lsu_unit.sv
// lsu_unit: load/store unit between the execute stage and the data memory.
// It runs one data-memory bus transaction per accepted request, with
// byte-lane steering, byte enables, a wait-state handshake and a timeout.
// It returns extended load data with a one-cycle done pulse.
//
// Ports:
//   clk, reset_n               clock (rising edge), async active-low reset
//   mem_read, mem_write        load / store request from the decoder
//   inst_size, load_unsigned   access size (00 b, 01 h, 1x w), zero-extend loads
//   addr, wdata                byte address, right-aligned store data
//   busy, done, rdata, fault   status towards the pipeline (rdata/fault valid with done)
//   bus_req, bus_we, bus_addr,
//   bus_be, bus_wdata          data-memory request, held until bus_ack
//   bus_ack, bus_rdata         data-memory completion and read word
module lsu_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  inst_size,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  // The counter only has to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] FAULT_OK       = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == 2'b01) && off[0]) || (size[1] && (off != 2'b00));
  endfunction

  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] steer_store(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] extract_load(input logic [1:0] size, input logic uns,
                                               input logic [1:0] off, input logic [31:0] word);
    logic [31:0] sh;
    case (size)
      2'b00: begin
        sh = word >> {off, 3'b000};
        return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        sh = word >> {off[1], 4'b0000};
        return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      end
      default: return word;
    endcase
  endfunction

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       req_size, req_size_nxt;
  logic             req_uns, req_uns_nxt;
  logic [1:0]       req_off, req_off_nxt;

  logic        busy_nxt, done_nxt, bus_req_nxt, bus_we_nxt;
  logic [31:0] rdata_nxt, bus_addr_nxt, bus_wdata_nxt;
  logic [1:0]  fault_nxt;
  logic [3:0]  bus_be_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_size  <= 2'b00;
      req_uns   <= 1'b0;
      req_off   <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 2'b00;
      rdata     <= 32'h0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_be    <= 4'h0;
      bus_wdata <= 32'h0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      req_size  <= req_size_nxt;
      req_uns   <= req_uns_nxt;
      req_off   <= req_off_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      fault     <= fault_nxt;
      rdata     <= rdata_nxt;
      bus_req   <= bus_req_nxt;
      bus_we    <= bus_we_nxt;
      bus_addr  <= bus_addr_nxt;
      bus_be    <= bus_be_nxt;
      bus_wdata <= bus_wdata_nxt;
    end
  end

  // Next-state and next-output logic; every output is a register, so the
  // values computed here appear one cycle after the deciding input.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    req_size_nxt  = req_size;
    req_uns_nxt   = req_uns;
    req_off_nxt   = req_off;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    fault_nxt     = fault;
    rdata_nxt     = rdata;
    bus_req_nxt   = bus_req;
    bus_we_nxt    = bus_we;
    bus_addr_nxt  = bus_addr;
    bus_be_nxt    = bus_be;
    bus_wdata_nxt = bus_wdata;

    case (state)
      IDLE: begin
        if (mem_read && mem_write) begin
          state_nxt = RESP;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b1;
          fault_nxt = FAULT_ILLEGAL;
          rdata_nxt = 32'h0;
        end else if (mem_read || mem_write) begin
          if (misaligned(inst_size, addr[1:0])) begin
            state_nxt = RESP;
            busy_nxt  = 1'b1;
            done_nxt  = 1'b1;
            fault_nxt = FAULT_MISALIGN;
            rdata_nxt = 32'h0;
          end else begin
            state_nxt     = BUS;
            cnt_nxt       = '0;
            req_size_nxt  = inst_size;
            req_uns_nxt   = load_unsigned;
            req_off_nxt   = addr[1:0];
            busy_nxt      = 1'b1;
            bus_req_nxt   = 1'b1;
            bus_we_nxt    = mem_write;
            bus_addr_nxt  = {addr[31:2], 2'b00};
            bus_be_nxt    = lane_enables(inst_size, addr[1:0]);
            bus_wdata_nxt = steer_store(inst_size, wdata);
          end
        end
      end

      BUS: begin
        // An ack in the last counted cycle wins over the timeout.
        if (bus_ack) begin
          state_nxt   = RESP;
          bus_req_nxt = 1'b0;
          done_nxt    = 1'b1;
          fault_nxt   = FAULT_OK;
          rdata_nxt   = bus_we ? 32'h0 : extract_load(req_size, req_uns, req_off, bus_rdata);
        end else if (cnt == CNT_LAST) begin
          state_nxt   = RESP;
          bus_req_nxt = 1'b0;
          done_nxt    = 1'b1;
          fault_nxt   = FAULT_TIMEOUT;
          rdata_nxt   = 32'h0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      RESP: begin
        state_nxt     = IDLE;
        busy_nxt      = 1'b0;
        fault_nxt     = FAULT_OK;
        rdata_nxt     = 32'h0;
        bus_we_nxt    = 1'b0;
        bus_addr_nxt  = 32'h0;
        bus_be_nxt    = 4'h0;
        bus_wdata_nxt = 32'h0;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_unit.sv
module tb_lsu_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  inst_size = 2'b00;
  logic        load_unsigned = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done;
  logic [31:0] rdata;
  logic [1:0]  fault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  lsu_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_read(mem_read), .mem_write(mem_write), .inst_size(inst_size),
    .load_unsigned(load_unsigned), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .fault(fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  fault;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   compared = 0;
  int   mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done) begin
      chk("done_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("sb_fault", 32'(fault), 32'(mon_e.fault));
        chk("sb_rdata", rdata, mon_e.rdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd);
    mem_read = rd; mem_write = wr; inst_size = sz;
    load_unsigned = uns; addr = a; wdata = wd;
  endtask

  task automatic idle_in();
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // Zero-wait access: request in T, ack in T+1, done in T+2, idle in T+3.
  task automatic zero_wait(input string tag, input logic rd, input logic wr,
                           input logic [1:0] sz, input logic uns, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rword,
                           input logic [3:0] be_exp, input logic [31:0] wd_exp,
                           input logic [31:0] rd_exp);
    drive(rd, wr, sz, uns, a, wd);
    exp_q.push_back('{2'b00, rd_exp});
    tick(); idle_in();
    chk({tag, "_bus_req"},  32'(bus_req), 32'd1);
    chk({tag, "_bus_we"},   32'(bus_we), 32'(wr));
    chk({tag, "_bus_addr"}, bus_addr, {a[31:2], 2'b00});
    chk({tag, "_bus_be"},   32'(bus_be), 32'(be_exp));
    if (wr) chk({tag, "_bus_wdata"}, bus_wdata, wd_exp);
    bus_ack = 1'b1; bus_rdata = rword;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    chk({tag, "_done"},    32'(done), 32'd1);
    chk({tag, "_req_off"}, 32'(bus_req), 32'd0);
    chk({tag, "_rdata"},   rdata, rd_exp);
    tick();
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic fault_case(input string tag, input logic rd, input logic wr,
                            input logic [1:0] sz, input logic [31:0] a, input logic [1:0] f_exp);
    drive(rd, wr, sz, 1'b0, a, 32'hA5A5A5A5);
    exp_q.push_back('{f_exp, 32'h0});
    tick(); idle_in();
    chk({tag, "_done"},    32'(done), 32'd1);
    chk({tag, "_fault"},   32'(fault), 32'(f_exp));
    chk({tag, "_busy"},    32'(busy), 32'd1);
    chk({tag, "_bus_req"}, 32'(bus_req), 32'd0);
    tick();
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_no_req"},   32'(bus_req), 32'd0);
  endtask

  initial begin
    // Reset
    #3 reset_n = 1'b0;
    tick(); tick();
    chk("rst_status", {busy, done, fault, rdata[27:0]}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_bus", {bus_req, bus_we, bus_be, 26'h0}, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    reset_n = 1'b1;
    tick();

    // Store word with wait states, ack at T+3
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
    exp_q.push_back('{2'b00, 32'h0});
    tick(); idle_in();
    for (int i = 1; i <= 3; i++) begin
      chk("sw_bus_req", 32'(bus_req), 32'd1);
      chk("sw_busy", 32'(busy), 32'd1);
      chk("sw_bus_addr", bus_addr, 32'h100);
      chk("sw_bus_be", 32'(bus_be), 32'hF);
      chk("sw_bus_wdata", bus_wdata, 32'hDEADBEEF);
      chk("sw_bus_we", 32'(bus_we), 32'd1);
      chk("sw_no_done", 32'(done), 32'd0);
      if (i == 3) begin bus_ack = 1'b1; bus_rdata = 32'h13572468; end
      tick();
    end
    bus_ack = 1'b0;
    chk("sw_done", 32'(done), 32'd1);
    chk("sw_busy_resp", 32'(busy), 32'd1);
    chk("sw_req_drop", 32'(bus_req), 32'd0);
    tick();
    chk("sw_busy_end", 32'(busy), 32'd0);
    chk("sw_done_end", 32'(done), 32'd0);

    // Byte / half / word loads and stores
    zero_wait("lb",  1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FF1234, 4'b1000, 32'h0, 32'hFFFFFF80);
    zero_wait("lbu", 1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF1234, 4'b1000, 32'h0, 32'h00000080);
    zero_wait("lb1", 1'b1, 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'h80FF1234, 4'b0010, 32'h0, 32'h00000012);
    zero_wait("sh",  1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 32'h0, 4'b1100, 32'hABCDABCD, 32'h0);
    zero_wait("lh",  1'b1, 1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 32'h8001FFFF, 4'b1100, 32'h0, 32'hFFFF8001);
    zero_wait("lhu", 1'b1, 1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 32'h8001FFFF, 4'b1100, 32'h0, 32'h00008001);
    zero_wait("lh0", 1'b1, 1'b0, 2'b01, 1'b0, 32'h200, 32'h0, 32'h8001FFFF, 4'b0011, 32'h0, 32'hFFFFFFFF);
    zero_wait("sb",  1'b0, 1'b1, 2'b00, 1'b0, 32'h001, 32'h7766555A, 32'h0, 4'b0010, 32'h5A5A5A5A, 32'h0);
    zero_wait("lwu", 1'b1, 1'b0, 2'b10, 1'b1, 32'h300, 32'h0, 32'h89ABCDEF, 4'b1111, 32'h0, 32'h89ABCDEF);
    zero_wait("lw11", 1'b1, 1'b0, 2'b11, 1'b0, 32'h304, 32'h0, 32'hF0E1D2C3, 4'b1111, 32'h0, 32'hF0E1D2C3);

    // Faults
    fault_case("mis_lw",   1'b1, 1'b0, 2'b10, 32'h101, 2'b01);
    fault_case("mis_sh",   1'b0, 1'b1, 2'b01, 32'h203, 2'b01);
    fault_case("mis_sz11", 1'b1, 1'b0, 2'b11, 32'h102, 2'b01);
    fault_case("illegal",  1'b1, 1'b1, 2'b10, 32'h100, 2'b11);

    // Timeout: never ack
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    exp_q.push_back('{2'b10, 32'h0});
    tick(); idle_in();
    for (int i = 0; i < 4; i++) begin
      chk("to_bus_req", 32'(bus_req), 32'd1);
      chk("to_no_done", 32'(done), 32'd0);
      tick();
    end
    chk("to_done", 32'(done), 32'd1);
    chk("to_fault", 32'(fault), 32'd2);
    chk("to_req_drop", 32'(bus_req), 32'd0);
    tick();

    // Ack in the final counted cycle succeeds
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h404, 32'h0);
    exp_q.push_back('{2'b00, 32'h11223344});
    tick(); idle_in();
    for (int i = 0; i < 3; i++) begin
      chk("late_bus_req", 32'(bus_req), 32'd1);
      tick();
    end
    chk("late_bus_req_last", 32'(bus_req), 32'd1);
    bus_ack = 1'b1; bus_rdata = 32'h11223344;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    chk("late_done", 32'(done), 32'd1);
    chk("late_fault", 32'(fault), 32'd0);
    tick();

    // Reset mid-BUS: request abandoned without done
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h500, 32'hCAFEF00D);
    tick(); idle_in();
    chk("rstbus_req", 32'(bus_req), 32'd1);
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("rstbus_req_async", 32'(bus_req), 32'd0);
    chk("rstbus_busy_async", 32'(busy), 32'd0);
    chk("rstbus_no_done", 32'(done), 32'd0);
    tick();
    chk("rstbus_no_done2", 32'(done), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("rstbus_idle", 32'(busy), 32'd0);

    // Back-to-back stores with mem_write held high
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h600, 32'h11111111);
    exp_q.push_back('{2'b00, 32'h0});
    tick();
    chk("b2b_a_addr", bus_addr, 32'h600);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("b2b_a_done", 32'(done), 32'd1);
    addr = 32'h604; wdata = 32'h22222222;
    tick();
    chk("b2b_gap_busy", 32'(busy), 32'd0);
    chk("b2b_gap_req", 32'(bus_req), 32'd0);
    exp_q.push_back('{2'b00, 32'h0});
    tick();
    chk("b2b_b_req", 32'(bus_req), 32'd1);
    chk("b2b_b_addr", bus_addr, 32'h604);
    // Inputs changed during BUS must not disturb the transaction
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h999, 32'h33333333);
    tick();
    idle_in();
    chk("b2b_hold_addr", bus_addr, 32'h604);
    chk("b2b_hold_wdata", bus_wdata, 32'h22222222);
    chk("b2b_hold_we", 32'(bus_we), 32'd1);
    chk("b2b_hold_be", 32'(bus_be), 32'hF);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("b2b_b_done", 32'(done), 32'd1);
    tick();
    chk("b2b_end_busy", 32'(busy), 32'd0);
    tick();
    chk("b2b_no_extra_done", 32'(done), 32'd0);

    chk("sb_pending", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
